// File: rtl/sha256_pkg.sv
// Shared SHA-2 accelerator types: message beat and hash ID widths.
// Also used by sha256_id_buf.
package sha256_pkg;

    localparam int unsigned DATA_W = 512;
    localparam int unsigned ID_W   = 6;

    typedef logic [ID_W-1:0]   sha256_id_t;
    typedef logic [DATA_W-1:0] sha256_data_t;

    typedef struct packed {
        logic         last;
        sha256_data_t data;
    } sha256_beat_t;

endpackage

// File: rtl/sha256_id_issue_if.sv
// Streams around the ID issue stage: bus-side ingress, message-builder egress,
// and the one-beat ID stream to sha256_id_buf.
interface sha256_id_issue_if;
    import sha256_pkg::*;

    sha256_data_t data_in;
    logic         data_in_last;
    logic         data_in_valid;
    logic         data_in_ready;

    sha256_data_t data_out;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready;

    sha256_id_t   id_out;
    logic         id_out_last;
    logic         id_out_valid;
    logic         id_out_ready;

    modport master (
        output data_in, data_in_last, data_in_valid, data_out_ready, id_out_ready,
        input  data_in_ready, data_out, data_out_last, data_out_valid,
               id_out, id_out_last, id_out_valid
    );

    modport slave (
        input  data_in, data_in_last, data_in_valid, data_out_ready, id_out_ready,
        output data_in_ready, data_out, data_out_last, data_out_valid,
               id_out, id_out_last, id_out_valid
    );

endinterface

// File: rtl/sha256_reg_slice.sv
// Single-entry valid/ready register. The caller decides acceptance (load);
// free tells it whether the entry can take a new word this cycle.
module sha256_reg_slice
    import sha256_pkg::*;
#(
    parameter int unsigned W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         free
);

    logic [W-1:0] data_d, data_q;
    logic         valid_d, valid_q;

    // Reload wins over drain so back-to-back transfers keep valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign free      = !valid_q || out_ready;

endmodule

// File: rtl/sha256_id_issue.sv
// Ingress stage: forwards message beats unchanged and issues one ID beat from a
// free-running counter on the first beat of every message.
module sha256_id_issue
    import sha256_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                sync_rst,
    sha256_id_issue_if.slave    bus,
    output sha256_id_t          status_id
);

    sha256_beat_t slice_out;
    logic         d_free;
    logic         i_free;
    logic         acc;
    logic         id_load;

    sha256_id_t id_d, id_q;
    logic       id_valid_d, id_valid_q;
    logic       id_last_d, id_last_q;
    sha256_id_t status_d, status_q;
    sha256_id_t id_cnt_d, id_cnt_q;
    logic       sop_d, sop_q;

    // A start-of-packet beat also needs the ID slot; mid-packet beats do not.
    assign i_free            = !id_valid_q || bus.id_out_ready;
    assign bus.data_in_ready = en && !sync_rst && d_free && (!sop_q || i_free);
    assign acc               = bus.data_in_valid && bus.data_in_ready;
    assign id_load           = acc && sop_q;

    sha256_reg_slice #(
        .W ($bits(sha256_beat_t))
    ) u_data_slice (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (sync_rst),
        .load      (acc),
        .load_data ({bus.data_in_last, bus.data_in}),
        .out_ready (bus.data_out_ready),
        .out_data  (slice_out),
        .out_valid (bus.data_out_valid),
        .free      (d_free)
    );

    always_comb begin
        id_d       = id_q;
        id_valid_d = id_valid_q;
        id_last_d  = id_last_q;
        status_d   = status_q;
        id_cnt_d   = id_cnt_q;
        sop_d      = sop_q;
        if (sync_rst) begin
            id_d       = '0;
            id_valid_d = 1'b0;
            id_last_d  = 1'b0;
            status_d   = '0;
            id_cnt_d   = '0;
            sop_d      = 1'b1;
        end else begin
            if (id_load) begin
                id_d       = id_cnt_q;
                id_valid_d = 1'b1;
                id_last_d  = 1'b1;
                status_d   = id_cnt_q;
                id_cnt_d   = id_cnt_q + 1'b1;
            end else if (bus.id_out_ready) begin
                id_valid_d = 1'b0;
            end
            if (acc) begin
                sop_d = bus.data_in_last;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            id_q       <= '0;
            id_valid_q <= 1'b0;
            id_last_q  <= 1'b0;
            status_q   <= '0;
            id_cnt_q   <= '0;
            sop_q      <= 1'b1;
        end else begin
            id_q       <= id_d;
            id_valid_q <= id_valid_d;
            id_last_q  <= id_last_d;
            status_q   <= status_d;
            id_cnt_q   <= id_cnt_d;
            sop_q      <= sop_d;
        end
    end

    assign bus.data_out      = slice_out.data;
    assign bus.data_out_last = slice_out.last;
    assign bus.id_out        = id_q;
    assign bus.id_out_last   = id_last_q;
    assign bus.id_out_valid  = id_valid_q;
    assign status_id         = status_q;

endmodule
